// File: rtl/mm_csr_timer.sv
// mm_csr_timer: memory-mapped CSR bank with a free-running compare timer and
// a level interrupt. It sits behind an AXI-lite to memory-mapped bridge and
// takes one-cycle write/read strobes from it.
//
// Ports:
//   aclk, areset        clock and synchronous active-high reset
//   i_mm_wen/waddr/wdata         write strobe, byte address, data
//   o_mm_invalid_waddr           write address unaligned or unmapped (combinational)
//   o_mm_invalid_w_op            write hits a read-only register (combinational)
//   i_mm_ren/raddr               read strobe and byte address
//   o_mm_rdata                   read data, one cycle after ren, held until next ren
//   o_mm_invalid_raddr           last read address unaligned or unmapped
//   o_mm_invalid_r_op            last read hit the write-only TIMER_CLR
//   o_irq                        IRQ_STATUS[0] & irq_en, registered
//
// Word map: 0 ID (RO), 1 CTRL (RW, bit0 timer_en, bit1 irq_en), 2 SCRATCH (RW),
// 3 TIMER_CNT (RO), 4 TIMER_CMP (RW), 5 IRQ_STATUS (W1C, bit0), 6 TIMER_CLR (WO).
module mm_csr_timer #(
    parameter int          ADDR_WIDTH = 64,
    parameter int          DATA_WIDTH = 64,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [63:0] ID_VALUE   = 64'h0000_0000_C5A7_0001
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  i_mm_wen,
    input  logic [ADDR_WIDTH-1:0] i_mm_waddr,
    input  logic [DATA_WIDTH-1:0] i_mm_wdata,
    output logic                  o_mm_invalid_waddr,
    output logic                  o_mm_invalid_w_op,
    input  logic                  i_mm_ren,
    input  logic [ADDR_WIDTH-1:0] i_mm_raddr,
    output logic [DATA_WIDTH-1:0] o_mm_rdata,
    output logic                  o_mm_invalid_raddr,
    output logic                  o_mm_invalid_r_op,
    output logic                  o_irq
);

    localparam int OFFS_W = $clog2(STRB_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - OFFS_W;

    localparam logic [IDX_W-1:0]      NUM_WORDS = IDX_W'(7);
    localparam logic [DATA_WIDTH-1:0] ZERO_D    = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONES_D    = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ONE_D     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ID_WORD   = ID_VALUE[DATA_WIDTH-1:0];

    localparam logic [2:0] IDX_ID      = 3'd0;
    localparam logic [2:0] IDX_CTRL    = 3'd1;
    localparam logic [2:0] IDX_SCRATCH = 3'd2;
    localparam logic [2:0] IDX_CNT     = 3'd3;
    localparam logic [2:0] IDX_CMP     = 3'd4;
    localparam logic [2:0] IDX_STATUS  = 3'd5;
    localparam logic [2:0] IDX_CLR     = 3'd6;

    // Aligned and word index inside the 7-word window; every address bit matters.
    function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[OFFS_W-1:0] == {OFFS_W{1'b0}}) &&
               (addr[ADDR_WIDTH-1:OFFS_W] < NUM_WORDS);
    endfunction

    // Architectural state
    logic [1:0]            ctrl_r;
    logic [DATA_WIDTH-1:0] scratch_r;
    logic [DATA_WIDTH-1:0] cnt_r;
    logic [DATA_WIDTH-1:0] cmp_r;
    logic                  irq_st_r;
    logic                  irq_r;

    // Read port registers
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  inv_raddr_r;
    logic                  inv_rop_r;

    // Write decode
    logic       w_addr_ok_s;
    logic [2:0] w_sel_s;
    logic       w_ro_s;
    logic       w_ok_s;
    logic       we_ctrl_s;
    logic       we_scratch_s;
    logic       we_cmp_s;
    logic       we_status_s;
    logic       we_clr_s;

    // Next-state values
    logic [1:0]            ctrl_nxt_s;
    logic [DATA_WIDTH-1:0] scratch_nxt_s;
    logic [DATA_WIDTH-1:0] cmp_nxt_s;
    logic [DATA_WIDTH-1:0] cnt_nxt_s;
    logic                  match_s;
    logic                  irq_st_nxt_s;
    logic                  irq_nxt_s;

    // Read decode
    logic                  r_addr_ok_s;
    logic [2:0]            r_sel_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  rd_inv_addr_s;
    logic                  rd_inv_op_s;

    // Decode the write address and classify read-only targets.
    always_comb begin
        w_addr_ok_s = addr_valid(i_mm_waddr);
        w_sel_s     = i_mm_waddr[OFFS_W+2:OFFS_W];
        case (w_sel_s)
            IDX_ID, IDX_CNT: w_ro_s = 1'b1;
            default:         w_ro_s = 1'b0;
        endcase
    end

    assign w_ok_s       = i_mm_wen & w_addr_ok_s & ~w_ro_s;
    assign we_ctrl_s    = w_ok_s & (w_sel_s == IDX_CTRL);
    assign we_scratch_s = w_ok_s & (w_sel_s == IDX_SCRATCH);
    assign we_cmp_s     = w_ok_s & (w_sel_s == IDX_CMP);
    assign we_status_s  = w_ok_s & (w_sel_s == IDX_STATUS);
    assign we_clr_s     = w_ok_s & (w_sel_s == IDX_CLR);

    // Invalid address wins, so the op flag only looks at mapped addresses.
    assign o_mm_invalid_waddr = i_mm_wen & ~w_addr_ok_s;
    assign o_mm_invalid_w_op  = i_mm_wen & w_addr_ok_s & w_ro_s;

    // Next-state logic for the CSRs, timer and interrupt status.
    always_comb begin
        if (we_ctrl_s) begin
            ctrl_nxt_s = i_mm_wdata[1:0];
        end else begin
            ctrl_nxt_s = ctrl_r;
        end

        if (we_scratch_s) begin
            scratch_nxt_s = i_mm_wdata;
        end else begin
            scratch_nxt_s = scratch_r;
        end

        if (we_cmp_s) begin
            cmp_nxt_s = i_mm_wdata;
        end else begin
            cmp_nxt_s = cmp_r;
        end

        // Clear beats increment; the increment uses the current timer_en so a
        // clear in the enabling cycle still yields 0 first.
        if (we_clr_s) begin
            cnt_nxt_s = ZERO_D;
        end else if (ctrl_r[0]) begin
            cnt_nxt_s = cnt_r + ONE_D;
        end else begin
            cnt_nxt_s = cnt_r;
        end

        // A match sets the status even if software is clearing it this cycle.
        match_s = ctrl_r[0] & (cnt_r == cmp_r);
        if (match_s) begin
            irq_st_nxt_s = 1'b1;
        end else if (we_status_s & i_mm_wdata[0]) begin
            irq_st_nxt_s = 1'b0;
        end else begin
            irq_st_nxt_s = irq_st_r;
        end

        // Computed from next values so o_irq tracks status & enable with no lag.
        irq_nxt_s = irq_st_nxt_s & ctrl_nxt_s[1];
    end

    // Read mux over the pre-write register values.
    always_comb begin
        r_addr_ok_s   = addr_valid(i_mm_raddr);
        r_sel_s       = i_mm_raddr[OFFS_W+2:OFFS_W];
        rd_word_s     = ZERO_D;
        rd_inv_addr_s = 1'b0;
        rd_inv_op_s   = 1'b0;
        if (!r_addr_ok_s) begin
            rd_inv_addr_s = 1'b1;
        end else begin
            case (r_sel_s)
                IDX_ID:      rd_word_s = ID_WORD;
                IDX_CTRL:    rd_word_s = {{(DATA_WIDTH-2){1'b0}}, ctrl_r};
                IDX_SCRATCH: rd_word_s = scratch_r;
                IDX_CNT:     rd_word_s = cnt_r;
                IDX_CMP:     rd_word_s = cmp_r;
                IDX_STATUS:  rd_word_s = {{(DATA_WIDTH-1){1'b0}}, irq_st_r};
                IDX_CLR:     rd_inv_op_s = 1'b1;
                default:     rd_word_s = ZERO_D;
            endcase
        end
    end

    // CSR, timer and interrupt state registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl_r    <= 2'b00;
            scratch_r <= ZERO_D;
            cnt_r     <= ZERO_D;
            cmp_r     <= ONES_D;
            irq_st_r  <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            ctrl_r    <= ctrl_nxt_s;
            scratch_r <= scratch_nxt_s;
            cnt_r     <= cnt_nxt_s;
            cmp_r     <= cmp_nxt_s;
            irq_st_r  <= irq_st_nxt_s;
            irq_r     <= irq_nxt_s;
        end
    end

    // Read response registers; held between strobes for a stalling bridge.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rdata_r     <= ZERO_D;
            inv_raddr_r <= 1'b0;
            inv_rop_r   <= 1'b0;
        end else if (i_mm_ren) begin
            rdata_r     <= rd_word_s;
            inv_raddr_r <= rd_inv_addr_s;
            inv_rop_r   <= rd_inv_op_s;
        end else begin
            rdata_r     <= rdata_r;
            inv_raddr_r <= inv_raddr_r;
            inv_rop_r   <= inv_rop_r;
        end
    end

    assign o_mm_rdata         = rdata_r;
    assign o_mm_invalid_raddr = inv_raddr_r;
    assign o_mm_invalid_r_op  = inv_rop_r;
    assign o_irq              = irq_r;

endmodule

// File: tb/tb_mm_csr_timer.sv
// Self-checking bench for mm_csr_timer with a transaction-level reference model.
module tb_mm_csr_timer;

    localparam logic [63:0] ID_V = 64'h0000_0000_C5A7_0001;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        i_mm_wen = 1'b0;
    logic [63:0] i_mm_waddr = 64'd0;
    logic [63:0] i_mm_wdata = 64'd0;
    logic        o_mm_invalid_waddr;
    logic        o_mm_invalid_w_op;
    logic        i_mm_ren = 1'b0;
    logic [63:0] i_mm_raddr = 64'd0;
    logic [63:0] o_mm_rdata;
    logic        o_mm_invalid_raddr;
    logic        o_mm_invalid_r_op;
    logic        o_irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_ctrl, m_scratch, m_cnt, m_cmp;
    logic        m_irq_st, m_irq;
    logic [63:0] m_rdata;
    logic        m_inv_raddr, m_inv_rop;

    mm_csr_timer dut (
        .aclk(aclk), .areset(areset),
        .i_mm_wen(i_mm_wen), .i_mm_waddr(i_mm_waddr), .i_mm_wdata(i_mm_wdata),
        .o_mm_invalid_waddr(o_mm_invalid_waddr), .o_mm_invalid_w_op(o_mm_invalid_w_op),
        .i_mm_ren(i_mm_ren), .i_mm_raddr(i_mm_raddr), .o_mm_rdata(o_mm_rdata),
        .o_mm_invalid_raddr(o_mm_invalid_raddr), .o_mm_invalid_r_op(o_mm_invalid_r_op),
        .o_irq(o_irq)
    );

    always #5 aclk = ~aclk;

    function automatic bit m_ok(input logic [63:0] a);
        return (a % 64'd8 == 64'd0) && (a / 64'd8 < 64'd7);
    endfunction

    function automatic int m_idx(input logic [63:0] a);
        return int'(a / 64'd8);
    endfunction

    function automatic logic [63:0] m_peek(input int idx);
        case (idx)
            0: return ID_V;
            1: return m_ctrl;
            2: return m_scratch;
            3: return m_cnt;
            4: return m_cmp;
            5: return {63'd0, m_irq_st};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic exp_inv_waddr();
        return i_mm_wen && !m_ok(i_mm_waddr);
    endfunction

    function automatic logic exp_inv_wop();
        return i_mm_wen && m_ok(i_mm_waddr) &&
               (m_idx(i_mm_waddr) == 0 || m_idx(i_mm_waddr) == 3);
    endfunction

    // Apply inputs at the start of a cycle and move to mid-cycle.
    task automatic drive(input logic rst, input logic we, input logic [63:0] wa,
                         input logic [63:0] wd, input logic re, input logic [63:0] ra);
        areset = rst; i_mm_wen = we; i_mm_waddr = wa; i_mm_wdata = wd;
        i_mm_ren = re; i_mm_raddr = ra;
        #3;
    endtask

    // Advance one clock, updating the model from the driven inputs.
    task automatic step();
        logic [63:0] n_ctrl, n_scratch, n_cnt, n_cmp;
        logic        n_irq_st, clr, w1c, match;
        int          wi;
        n_ctrl = m_ctrl; n_scratch = m_scratch; n_cmp = m_cmp;
        clr = 1'b0; w1c = 1'b0;
        if (i_mm_ren) begin
            if (!m_ok(i_mm_raddr)) begin
                m_rdata = 64'd0; m_inv_raddr = 1'b1; m_inv_rop = 1'b0;
            end else if (m_idx(i_mm_raddr) == 6) begin
                m_rdata = 64'd0; m_inv_raddr = 1'b0; m_inv_rop = 1'b1;
            end else begin
                m_rdata = m_peek(m_idx(i_mm_raddr)); m_inv_raddr = 1'b0; m_inv_rop = 1'b0;
            end
        end
        if (i_mm_wen && m_ok(i_mm_waddr)) begin
            wi = m_idx(i_mm_waddr);
            case (wi)
                1: n_ctrl = i_mm_wdata & 64'd3;
                2: n_scratch = i_mm_wdata;
                4: n_cmp = i_mm_wdata;
                5: w1c = i_mm_wdata[0];
                6: clr = 1'b1;
                default: ;
            endcase
        end
        match = m_ctrl[0] && (m_cnt == m_cmp);
        n_cnt = clr ? 64'd0 : (m_ctrl[0] ? m_cnt + 64'd1 : m_cnt);
        n_irq_st = match ? 1'b1 : (w1c ? 1'b0 : m_irq_st);
        if (areset) begin
            n_ctrl = 64'd0; n_scratch = 64'd0; n_cnt = 64'd0; n_cmp = '1; n_irq_st = 1'b0;
            m_rdata = 64'd0; m_inv_raddr = 1'b0; m_inv_rop = 1'b0;
        end
        @(posedge aclk);
        #1;
        m_ctrl = n_ctrl; m_scratch = n_scratch; m_cnt = n_cnt; m_cmp = n_cmp;
        m_irq_st = n_irq_st; m_irq = n_irq_st & n_ctrl[1];
        areset = 1'b0; i_mm_wen = 1'b0; i_mm_ren = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
        step();
        checks++;
        if ({o_mm_rdata, o_mm_invalid_raddr, o_mm_invalid_r_op, o_irq} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs rdata=%h iraddr=%b irop=%b irq=%b required all 0",
                     o_mm_rdata, o_mm_invalid_raddr, o_mm_invalid_r_op, o_irq);
        end
        // Back-to-back reads of the whole map.
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'(i * 8));
            step();
            checks++;
            if ({o_mm_rdata, o_mm_invalid_raddr, o_mm_invalid_r_op} !== {m_rdata, m_inv_raddr, m_inv_rop}) begin
                errors++;
                $display("FAIL reset_read idx%0d got %h/%b/%b required %h/%b/%b", i, o_mm_rdata,
                         o_mm_invalid_raddr, o_mm_invalid_r_op, m_rdata, m_inv_raddr, m_inv_rop);
            end
        end
        checks++;
        if (o_mm_invalid_r_op !== 1'b1) begin
            errors++;
            $display("FAIL timer_clr_read_op got %b required 1", o_mm_invalid_r_op);
        end
    endtask

    task automatic test_scratch();
        drive(1'b0, 1'b1, 64'd16, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'd0);
        checks++;
        if ({o_mm_invalid_waddr, o_mm_invalid_w_op} !== 2'b00) begin
            errors++;
            $display("FAIL scratch_wflags got %b%b required 00", o_mm_invalid_waddr, o_mm_invalid_w_op);
        end
        step();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd16);
        step();
        checks++;
        if (o_mm_rdata !== 64'hDEAD_BEEF_0123_4567) begin
            errors++;
            $display("FAIL scratch_readback got %h required %h", o_mm_rdata, 64'hDEAD_BEEF_0123_4567);
        end
        drive(1'b0, 1'b1, 64'd0, {$urandom, $urandom}, 1'b0, 64'd0);
        checks++;
        if ({o_mm_invalid_waddr, o_mm_invalid_w_op} !== 2'b01) begin
            errors++;
            $display("FAIL id_write_flags got %b%b required 01", o_mm_invalid_waddr, o_mm_invalid_w_op);
        end
        step();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd0);
        step();
        checks++;
        if (o_mm_rdata !== ID_V) begin
            errors++;
            $display("FAIL id_unchanged got %h required %h", o_mm_rdata, ID_V);
        end
    endtask

    task automatic test_invalid();
        logic [63:0] bad [2];
        bad[0] = 64'h0C; bad[1] = 64'h38;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, bad[i], {$urandom, $urandom}, 1'b0, 64'd0);
            checks++;
            if ({o_mm_invalid_waddr, o_mm_invalid_w_op} !== 2'b10) begin
                errors++;
                $display("FAIL bad_waddr %h got %b%b required 10", bad[i], o_mm_invalid_waddr, o_mm_invalid_w_op);
            end
            step();
            drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, bad[i]);
            step();
            checks++;
            if ({o_mm_rdata, o_mm_invalid_raddr, o_mm_invalid_r_op} !== {64'd0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL bad_raddr %h got %h/%b/%b required 0/1/0", bad[i], o_mm_rdata,
                         o_mm_invalid_raddr, o_mm_invalid_r_op);
            end
        end
        // Idle cycle: read results hold.
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
        step();
        checks++;
        if ({o_mm_rdata, o_mm_invalid_raddr} !== {64'd0, 1'b1}) begin
            errors++;
            $display("FAIL read_hold got %h/%b required 0/1", o_mm_rdata, o_mm_invalid_raddr);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'(i * 8));
            step();
            checks++;
            if (o_mm_rdata !== m_rdata) begin
                errors++;
                $display("FAIL no_change idx%0d got %h required %h", i, o_mm_rdata, m_rdata);
            end
        end
    endtask

    task automatic test_same_cycle_rw();
        logic [63:0] nv;
        nv = {$urandom, $urandom};
        drive(1'b0, 1'b1, 64'd16, nv, 1'b1, 64'd16);
        step();
        checks++;
        if (o_mm_rdata !== 64'hDEAD_BEEF_0123_4567) begin
            errors++;
            $display("FAIL rw_same_cycle got %h required %h", o_mm_rdata, 64'hDEAD_BEEF_0123_4567);
        end
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd16);
        step();
        checks++;
        if (o_mm_rdata !== nv) begin
            errors++;
            $display("FAIL rw_after got %h required %h", o_mm_rdata, nv);
        end
    endtask

    task automatic test_irq();
        int n;
        drive(1'b0, 1'b1, 64'd32, 64'd10, 1'b0, 64'd0); step();
        drive(1'b0, 1'b1, 64'd8, 64'd3, 1'b0, 64'd0); step();
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd24);
            step();
            checks++;
            if (o_mm_rdata !== 64'(k) || o_irq !== (k >= 10) || o_irq !== m_irq) begin
                errors++;
                $display("FAIL irq_match k=%0d cnt got %0d required %0d irq got %b required %b",
                         k, o_mm_rdata, k, o_irq, (k >= 10));
            end
        end
        drive(1'b0, 1'b1, 64'd40, 64'd1, 1'b0, 64'd0); step();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd40); step();
        checks++;
        if (o_irq !== 1'b0 || o_mm_rdata !== 64'd0) begin
            errors++;
            $display("FAIL w1c_clear irq got %b status got %h required 0/0", o_irq, o_mm_rdata);
        end
        drive(1'b0, 1'b1, 64'd48, 64'd0, 1'b0, 64'd0); step();
        n = 0;
        while (m_cnt != m_cmp && n < 40) begin
            drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0); step();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL match_wait_timeout cycles %0d required below 40", n);
        end
        drive(1'b0, 1'b1, 64'd40, 64'd1, 1'b0, 64'd0); step();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd40); step();
        checks++;
        if (o_irq !== 1'b1 || o_mm_rdata !== 64'd1) begin
            errors++;
            $display("FAIL set_beats_w1c irq got %b status got %h required 1/1", o_irq, o_mm_rdata);
        end
    endtask

    task automatic test_clear();
        drive(1'b0, 1'b1, 64'd48, {$urandom, $urandom}, 1'b0, 64'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd24);
            step();
            checks++;
            if (o_mm_rdata !== 64'(k)) begin
                errors++;
                $display("FAIL clr_resume k=%0d got %0d required %0d", k, o_mm_rdata, k);
            end
        end
    endtask

    task automatic test_reset_mid();
        checks++;
        if (o_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_before_reset got %b required 1", o_irq);
        end
        drive(1'b1, 1'b1, 64'd16, 64'h1234, 1'b1, 64'd0);
        step();
        checks++;
        if ({o_mm_rdata, o_mm_invalid_raddr, o_mm_invalid_r_op, o_irq} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid_out rdata=%h irq=%b required 0/0", o_mm_rdata, o_irq);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, (i == 0) ? 64'd24 : ((i == 1) ? 64'd40 : 64'd16));
            step();
            checks++;
            if (o_mm_rdata !== 64'd0) begin
                errors++;
                $display("FAIL reset_mid_reg %0d got %h required 0", i, o_mm_rdata);
            end
        end
    endtask

    task automatic test_random();
        int wi, ri;
        logic [63:0] wa, ra, wd;
        for (int c = 0; c < 400; c++) begin
            wi = $urandom_range(0, 8);
            ri = $urandom_range(0, 8);
            wa = 64'(wi * 8) + (($urandom_range(0, 7) == 0) ? 64'($urandom_range(1, 7)) : 64'd0);
            ra = 64'(ri * 8) + (($urandom_range(0, 7) == 0) ? 64'($urandom_range(1, 7)) : 64'd0);
            wd = (wi == 4) ? 64'($urandom_range(0, 40)) : {$urandom, $urandom};
            drive(($urandom_range(0, 60) == 0), $urandom_range(0, 1) == 1, wa, wd,
                  $urandom_range(0, 3) != 0, ra);
            checks++;
            if ({o_mm_invalid_waddr, o_mm_invalid_w_op} !== {exp_inv_waddr(), exp_inv_wop()}) begin
                errors++;
                $display("FAIL rand_wflags c=%0d addr %h got %b%b required %b%b", c, wa,
                         o_mm_invalid_waddr, o_mm_invalid_w_op, exp_inv_waddr(), exp_inv_wop());
            end
            step();
            checks++;
            if ({o_mm_rdata, o_mm_invalid_raddr, o_mm_invalid_r_op, o_irq} !==
                {m_rdata, m_inv_raddr, m_inv_rop, m_irq}) begin
                errors++;
                $display("FAIL rand_read c=%0d got %h/%b/%b/%b required %h/%b/%b/%b", c, o_mm_rdata,
                         o_mm_invalid_raddr, o_mm_invalid_r_op, o_irq, m_rdata, m_inv_raddr, m_inv_rop, m_irq);
            end
        end
    endtask

    initial begin
        @(posedge aclk);
        #1;
        test_reset();
        test_scratch();
        test_invalid();
        test_same_cycle_rw();
        test_irq();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mm_csr_timer.md
# mm_csr_timer

Memory-mapped control/status register bank with a compare timer and interrupt, sitting directly downstream of the AXI-lite to memory-mapped bridge. It consumes the bridge's single-cycle write and read strobes, returns read data one cycle after a read strobe, and reports invalid address and invalid operation flags back to the bridge. It drives one level interrupt output.

## Interface
Parameters:
- ADDR_WIDTH, 64, byte address width of the mm ports
- DATA_WIDTH, 64, register and data width; 32 or 64 only
- STRB_WIDTH, DATA_WIDTH/8, bytes per word; sets the address alignment
- ID_VALUE, 'h0000_0000_C5A7_0001, constant returned by the ID register

Ports:
- aclk  in  1  clock; all logic on the rising edge
- areset  in  1  reset; synchronous, active-high
- i_mm_wen  in  1  write strobe, one cycle per write
- i_mm_waddr  in  ADDR_WIDTH  write byte address
- i_mm_wdata  in  DATA_WIDTH  write data
- o_mm_invalid_waddr  out  1  current write address unaligned or unmapped
- o_mm_invalid_w_op  out  1  current write targets a read-only register
- i_mm_ren  in  1  read strobe, one cycle per read
- i_mm_raddr  in  ADDR_WIDTH  read byte address
- o_mm_rdata  out  DATA_WIDTH  read data, registered
- o_mm_invalid_raddr  out  1  last read address unaligned or unmapped, registered
- o_mm_invalid_r_op  out  1  last read targeted a write-only register, registered
- o_irq  out  1  interrupt, level

## Operation
- Decode: the address is aligned when the low log2(STRB_WIDTH) bits are 0. Word index = addr >> log2(STRB_WIDTH). Word indices 0 to 6 are mapped. An unaligned address, or an index of 7 or more, is an invalid address.
- Register map (word index: name, access, reset value):
  - 0: ID, RO, ID_VALUE
  - 1: CTRL, RW, 0. bit0 = timer_en, bit1 = irq_en, other bits read 0.
  - 2: SCRATCH, RW, 0
  - 3: TIMER_CNT, RO, 0
  - 4: TIMER_CMP, RW, all ones
  - 5: IRQ_STATUS, W1C, 0. Only bit0 is implemented.
  - 6: TIMER_CLR, WO. Any write clears TIMER_CNT. A read returns 0.
- Write with an invalid address or to an RO register: no state changes and the matching flag is raised. Invalid address takes priority; only one flag is raised per write.
- Read with an invalid address returns rdata 0 with invalid_raddr = 1. A read of TIMER_CLR returns 0 with invalid_r_op = 1.
- Timer: while timer_en = 1, TIMER_CNT increments by 1 each cycle and wraps from all ones to 0. It holds while timer_en = 0.
- TIMER_CLR write: TIMER_CNT = 0 next cycle. This overrides the increment.
- A TIMER_CLR write in the same cycle as a timer_en 0→1 write leaves TIMER_CNT = 0; incrementing starts the cycle after.
- Match: when timer_en = 1 and TIMER_CNT == TIMER_CMP, IRQ_STATUS[0] is set on the next edge.
  - A W1C clear of bit0 in the same cycle as a match: set wins.
- o_irq = IRQ_STATUS[0] & irq_en, registered outputs only, no combinational path from inputs.
- A read and a write in the same cycle to the same register: the read returns the pre-write value.

## Timing
- Write: the write takes effect on the edge ending the wen cycle. o_mm_invalid_waddr and o_mm_invalid_w_op are combinational from wen and waddr in that same cycle, and are 0 whenever wen = 0.
- Read: 1-cycle latency. rdata and both read flags are captured on the edge ending the ren cycle. They are held until the next ren, to suit a bridge that stalls rvalid.
- TIMER_CNT read: returns the count value present during the ren cycle.
- Reset: on the aclk edge with areset = 1, all registers take their reset values. Also o_mm_rdata = 0, read flags = 0, o_irq = 0. Reset overrides any concurrent wen or ren.
- Reset mid-count clears TIMER_CNT and a pending IRQ_STATUS.
- Back-to-back ren on consecutive cycles is supported; each result appears exactly one cycle after its strobe.

## Test plan
- Reset, then read indices 0 to 6:
  - rdata = ID_VALUE, 0, 0, 0, all ones, 0, 0.
  - Index 6 gives invalid_r_op = 1; all others give no flags.
- Write SCRATCH = 'hDEAD_BEEF_0123_4567, then read it back:
  - Read returns the written value.
  - A write to ID raises invalid_w_op = 1 in the wen cycle and ID is unchanged.
- Unaligned address 'h0C and unmapped address 'h38, for both a write and a read:
  - Write: invalid_waddr = 1 in the wen cycle.
  - Read: invalid_raddr = 1 and rdata = 0 on the next cycle.
  - No register changes.
- Set TIMER_CMP = 10, then CTRL = 3:
  - IRQ_STATUS[0] and o_irq go to 1 exactly 1 cycle after TIMER_CNT == 10.
  - W1C of bit0 drops o_irq.
  - A W1C in the same cycle as a match leaves bit0 = 1.
- Wrap and clear:
  - Timer counts past all ones to 0.
  - A TIMER_CLR write gives TIMER_CNT = 0 on the next cycle, then counting resumes.
  - areset asserted mid-count zeroes TIMER_CNT, IRQ_STATUS and o_irq.
